// File: rtl/lsu_misalign_seq_pkg.sv
// Shared op codes, state encoding and op decode helpers for the load/store sequencer.
// Store op codes (SB/SH/SW) share the LB/LH/LW encodings.
package lsu_misalign_seq_pkg;

    localparam logic [2:0] OP_LB  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LW  = 3'b010;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_LHU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LO   = 3'd1,
        ST_HI   = 3'd2,
        ST_RESP = 3'd3,
        ST_DONE = 3'd4
    } lsu_state_e;

    function automatic logic [2:0] op_size(input logic [2:0] op);
        case (op)
            OP_LB, OP_LBU: return 3'd1;
            OP_LH, OP_LHU: return 3'd2;
            default:       return 3'd4;
        endcase
    endfunction

    function automatic logic op_illegal(input logic [2:0] op, input logic store);
        if (store)
            return op >= 3'b011;
        else
            return (op == 3'b011) || (op == 3'b110) || (op == 3'b111);
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane math: byte-enable masks, store data shift and load extract/extend.
module lsu_lane_align
    import lsu_misalign_seq_pkg::*;
(
    input  logic [1:0]  offset,
    input  logic [2:0]  op,
    input  logic [31:0] store_data,
    input  logic [31:0] read_word,
    input  logic [31:0] lo_word,
    output logic        split,
    output logic [3:0]  lo_be,
    output logic [3:0]  hi_be,
    output logic [31:0] lo_wdata,
    output logic [31:0] hi_wdata,
    output logic [31:0] load_result
);

    logic [2:0]  size;
    logic [3:0]  end_byte;
    logic [7:0]  size_mask;
    logic [7:0]  mask8;
    logic [4:0]  shamt;
    logic [63:0] wdata64;
    logic [63:0] rdata64;
    logic [31:0] shifted;

    assign size     = op_size(op);
    assign end_byte = {2'b00, offset} + {1'b0, size};
    assign split    = end_byte > 4'd4;
    assign shamt    = {offset, 3'b000};

    always_comb begin
        size_mask = 8'h0F;
        case (size)
            3'd1:    size_mask = 8'h01;
            3'd2:    size_mask = 8'h03;
            default: size_mask = 8'h0F;
        endcase
    end

    assign mask8 = size_mask << offset;
    assign lo_be = mask8[3:0];
    assign hi_be = mask8[7:4];

    assign wdata64  = {32'h0, store_data} << shamt;
    assign lo_wdata = wdata64[31:0];
    assign hi_wdata = wdata64[63:32];

    // For a split load the high word is the one arriving now and the low word was captured earlier.
    assign rdata64 = split ? {read_word, lo_word} : {32'h0, read_word};
    assign shifted = 32'(rdata64 >> shamt);

    always_comb begin
        load_result = '0;
        case (op)
            OP_LB:   load_result = {{24{shifted[7]}}, shifted[7:0]};
            OP_LBU:  load_result = {24'h0, shifted[7:0]};
            OP_LH:   load_result = {{16{shifted[15]}}, shifted[15:0]};
            OP_LHU:  load_result = {16'h0, shifted[15:0]};
            OP_LW:   load_result = shifted;
            default: load_result = '0;
        endcase
    end

endmodule

// File: rtl/lsu_misalign_seq.sv
// Load/store sequencer: issues one or two word-aligned data_mem accesses per core request,
// reassembles split loads and stalls the core until a one-cycle done pulse.
module lsu_misalign_seq
    import lsu_misalign_seq_pkg::*;
#(
    parameter logic SPLIT_EN   = 1'b1,
    parameter int   ADDR_WIDTH = 32
) (
    input  logic                  Clk_Core,
    input  logic                  Rst_Core_N,
    input  logic                  Mem_Req,
    input  logic [ADDR_WIDTH-1:0] Mem_Addr,
    input  logic [2:0]            Lw_Sw_OP,
    input  logic                  Store_Word_Ctrl,
    input  logic [31:0]           Register_In_B,
    input  logic [31:0]           Mem_Data_Read,
    output logic [ADDR_WIDTH-1:0] Mem_Data_Address,
    output logic                  Read_Ctrl,
    output logic [3:0]            Data_Mem_Write_Ctrl,
    output logic [31:0]           Data_Mem_Write_Out,
    output logic [31:0]           Load_Data,
    output logic                  Lsu_Stall,
    output logic                  Lsu_Done,
    output logic                  Lsu_Err,
    output lsu_state_e            Lsu_State
);

    lsu_state_e            state;
    logic [1:0]            off_q;
    logic [2:0]            op_q;
    logic                  store_q;
    logic [31:0]           data_q;
    logic [31:0]           lo_word_q;
    logic [ADDR_WIDTH-1:0] addr_out_q;
    logic                  rd_q;
    logic [3:0]            be_q;
    logic [31:0]           wd_q;
    logic [31:0]           load_q;
    logic                  done_q;
    logic                  err_q;

    logic [1:0]  cur_off;
    logic [2:0]  cur_op;
    logic [31:0] cur_data;
    logic        split;
    logic [3:0]  lo_be;
    logic [3:0]  hi_be;
    logic [31:0] lo_wdata;
    logic [31:0] hi_wdata;
    logic [31:0] load_result;
    logic        illegal;

    // In IDLE the lane math looks at the live request; afterwards at the captured one.
    assign cur_off  = (state == ST_IDLE) ? Mem_Addr[1:0]  : off_q;
    assign cur_op   = (state == ST_IDLE) ? Lw_Sw_OP       : op_q;
    assign cur_data = (state == ST_IDLE) ? Register_In_B  : data_q;

    lsu_lane_align u_lane (
        .offset      (cur_off),
        .op          (cur_op),
        .store_data  (cur_data),
        .read_word   (Mem_Data_Read),
        .lo_word     (lo_word_q),
        .split       (split),
        .lo_be       (lo_be),
        .hi_be       (hi_be),
        .lo_wdata    (lo_wdata),
        .hi_wdata    (hi_wdata),
        .load_result (load_result)
    );

    assign illegal = op_illegal(Lw_Sw_OP, Store_Word_Ctrl) || (split && !SPLIT_EN);

    always_ff @(posedge Clk_Core) begin
        if (!Rst_Core_N) begin
            state      <= ST_IDLE;
            off_q      <= '0;
            op_q       <= '0;
            store_q    <= 1'b0;
            data_q     <= '0;
            lo_word_q  <= '0;
            addr_out_q <= '0;
            rd_q       <= 1'b0;
            be_q       <= '0;
            wd_q       <= '0;
            load_q     <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            rd_q   <= 1'b0;
            be_q   <= '0;
            wd_q   <= '0;
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (Mem_Req) begin
                        off_q   <= Mem_Addr[1:0];
                        op_q    <= Lw_Sw_OP;
                        store_q <= Store_Word_Ctrl;
                        data_q  <= Register_In_B;
                        load_q  <= '0;
                        if (illegal) begin
                            state  <= ST_DONE;
                            done_q <= 1'b1;
                            err_q  <= 1'b1;
                        end else begin
                            state      <= ST_LO;
                            err_q      <= 1'b0;
                            addr_out_q <= {Mem_Addr[ADDR_WIDTH-1:2], 2'b00};
                            if (Store_Word_Ctrl) begin
                                be_q <= lo_be;
                                wd_q <= lo_wdata;
                            end else begin
                                rd_q <= 1'b1;
                            end
                        end
                    end
                end
                ST_LO: begin
                    if (split) begin
                        state      <= ST_HI;
                        addr_out_q <= addr_out_q + ADDR_WIDTH'(4);
                        if (store_q) begin
                            be_q <= hi_be;
                            wd_q <= hi_wdata;
                        end else begin
                            rd_q <= 1'b1;
                        end
                    end else begin
                        state <= ST_RESP;
                    end
                end
                ST_HI: begin
                    lo_word_q <= Mem_Data_Read;
                    state     <= ST_RESP;
                end
                ST_RESP: begin
                    load_q <= store_q ? 32'h0 : load_result;
                    done_q <= 1'b1;
                    state  <= ST_DONE;
                end
                ST_DONE: begin
                    err_q <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Enables are gated by reset directly so an interrupted split store cannot commit its second half.
    assign Data_Mem_Write_Ctrl = Rst_Core_N ? be_q : 4'b0000;
    assign Mem_Data_Address    = addr_out_q;
    assign Read_Ctrl           = rd_q;
    assign Data_Mem_Write_Out  = wd_q;
    assign Load_Data           = load_q;
    assign Lsu_Done            = done_q;
    assign Lsu_Err             = err_q;
    assign Lsu_Stall           = (state == ST_IDLE) ? Mem_Req : (state != ST_DONE);
    assign Lsu_State           = state;

endmodule

// File: tb/tb_lsu_misalign_seq.sv
// Directed bench for lsu_misalign_seq: byte-level memory model, access/result scoreboards.
module tb_lsu_misalign_seq;
    import lsu_misalign_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_req;
    logic        req2;
    logic [31:0] mem_addr;
    logic [2:0]  op;
    logic        st;
    logic [31:0] wdata_in;
    logic [31:0] rdata = '0;

    logic [31:0] maddr;
    logic        rd_ctrl;
    logic [3:0]  wctrl;
    logic [31:0] wout;
    logic [31:0] load_data;
    logic        stall;
    logic        done;
    logic        err;
    lsu_state_e  st_dbg;

    logic [31:0] n2_maddr;
    logic        n2_rd;
    logic [3:0]  n2_be;
    logic [31:0] n2_wout;
    logic [31:0] n2_load;
    logic        n2_stall;
    logic        n2_done;
    logic        n2_err;
    lsu_state_e  n2_state;
    logic        n2_touched = 1'b0;

    int n_cmp = 0;
    int n_fail = 0;

    logic [31:0] dmem [0:15];
    logic [7:0]  ref_mem [0:63];
    // {addr[31:0], rd, be[3:0], wdata[31:0]}
    logic [68:0] exp_q [$];
    // {err, load_data[31:0]}
    logic [32:0] res_q [$];

    always #5 clk = ~clk;

    lsu_misalign_seq #(.SPLIT_EN(1'b1), .ADDR_WIDTH(32)) dut (
        .Clk_Core(clk), .Rst_Core_N(rst_n), .Mem_Req(mem_req), .Mem_Addr(mem_addr),
        .Lw_Sw_OP(op), .Store_Word_Ctrl(st), .Register_In_B(wdata_in), .Mem_Data_Read(rdata),
        .Mem_Data_Address(maddr), .Read_Ctrl(rd_ctrl), .Data_Mem_Write_Ctrl(wctrl),
        .Data_Mem_Write_Out(wout), .Load_Data(load_data), .Lsu_Stall(stall),
        .Lsu_Done(done), .Lsu_Err(err), .Lsu_State(st_dbg)
    );

    lsu_misalign_seq #(.SPLIT_EN(1'b0), .ADDR_WIDTH(32)) dut_ns (
        .Clk_Core(clk), .Rst_Core_N(rst_n), .Mem_Req(req2), .Mem_Addr(mem_addr),
        .Lw_Sw_OP(op), .Store_Word_Ctrl(st), .Register_In_B(wdata_in), .Mem_Data_Read(rdata),
        .Mem_Data_Address(n2_maddr), .Read_Ctrl(n2_rd), .Data_Mem_Write_Ctrl(n2_be),
        .Data_Mem_Write_Out(n2_wout), .Load_Data(n2_load), .Lsu_Stall(n2_stall),
        .Lsu_Done(n2_done), .Lsu_Err(n2_err), .Lsu_State(n2_state)
    );

    // data_mem: synchronous read, per-byte write
    always @(posedge clk) begin
        if (rd_ctrl) rdata <= dmem[maddr[5:2]];
        for (int i = 0; i < 4; i++)
            if (wctrl[i]) dmem[maddr[5:2]][8*i +: 8] <= wout[8*i +: 8];
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        n_cmp++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, got, expv);
        end
    endtask

    function automatic int model_size(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    // Expected access to word w: byte lanes touched by the request bytes that land in w.
    task automatic push_acc(input logic is_st, input logic [31:0] w, input logic [31:0] a,
                            input int s, input logic [31:0] d);
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] ba;
        int lane;
        be = '0;
        wd = '0;
        for (int i = 0; i < s; i++) begin
            ba = a + i;
            if ((ba & ~32'h3) == w) begin
                lane = int'(ba[1:0]);
                be[lane] = 1'b1;
                wd[8*lane +: 8] = d[8*i +: 8];
            end
        end
        exp_q.push_back({w, !is_st, is_st ? be : 4'b0000, is_st ? wd : 32'h0});
    endtask

    task automatic do_req(input logic is_st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, output logic [31:0] got);
        int s;
        int lat;
        int n;
        logic spl;
        logic ill;
        logic [31:0] w0;
        logic [31:0] ba;
        logic [31:0] v;
        s   = model_size(f3);
        spl = ((a + s - 1) >> 2) != (a >> 2);
        ill = is_st ? (f3 > 3'd2) : (f3 == 3'b011 || f3 >= 3'b110);
        v   = '0;
        if (!ill) begin
            w0 = a & ~32'h3;
            push_acc(is_st, w0, a, s, d);
            if (spl) push_acc(is_st, w0 + 32'd4, a, s, d);
            for (int i = 0; i < s; i++) begin
                ba = a + i;
                if (is_st) ref_mem[ba[5:0]] = d[8*i +: 8];
                else v[8*i +: 8] = ref_mem[ba[5:0]];
            end
            if (!is_st && f3 == 3'b000 && v[7])  v = v | 32'hFFFF_FF00;
            if (!is_st && f3 == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
        end
        lat = ill ? 1 : (spl ? 4 : 3);
        res_q.push_back({ill, v});

        @(posedge clk); #1;
        mem_addr = a; op = f3; st = is_st; wdata_in = d; mem_req = 1'b1;
        #1 chk("stall_accept", {31'b0, stall}, 32'd1);
        n = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            n = k;
            if (done) break;
            chk("stall_busy", {31'b0, stall}, 32'd1);
        end
        chk("latency", n, lat);
        chk("stall_done", {31'b0, stall}, 32'd0);
        got = load_data;
        mem_req = 1'b0;
    endtask

    // Compare process: every data_mem access and every completion against the model queues.
    always @(negedge clk) begin
        logic [68:0] e;
        logic [32:0] r;
        if (rst_n) begin
            if (rd_ctrl || (|wctrl)) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL unexpected_access: got addr %h be %b rd %b, required none", maddr, wctrl, rd_ctrl);
                end else begin
                    e = exp_q.pop_front();
                    chk("acc_addr", maddr, e[68:37]);
                    chk("acc_rd", {31'b0, rd_ctrl}, {31'b0, e[36]});
                    chk("acc_be", {28'b0, wctrl}, {28'b0, e[35:32]});
                    if (e[35:32] != 4'b0000) chk("acc_wdata", wout, e[31:0]);
                end
            end
            if (st_dbg == ST_IDLE || st_dbg == ST_RESP || st_dbg == ST_DONE) begin
                chk("quiet_ctrl", {27'b0, rd_ctrl, wctrl}, 32'd0);
                chk("quiet_wdata", wout, 32'd0);
            end
            if (done) begin
                if (res_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL unexpected_done: got done, required none");
                end else begin
                    r = res_q.pop_front();
                    chk("done_err", {31'b0, err}, {31'b0, r[32]});
                    chk("done_data", load_data, r[31:0]);
                end
            end
        end
        if (n2_rd || (|n2_be)) n2_touched = 1'b1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got;
        logic [31:0] w0;
        for (int i = 0; i < 16; i++) dmem[i] = '0;
        for (int i = 0; i < 64; i++) ref_mem[i] = '0;
        rst_n = 1'b0; mem_req = 1'b0; req2 = 1'b0;
        mem_addr = '0; op = '0; st = 1'b0; wdata_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", 32'(st_dbg), 32'(ST_IDLE));
        chk("rst_addr", maddr, 32'd0);
        chk("rst_ctrl", {27'b0, rd_ctrl, wctrl}, 32'd0);
        chk("rst_wdata", wout, 32'd0);
        chk("rst_load", load_data, 32'd0);
        chk("rst_flags", {29'b0, stall, done, err}, 32'd0);
        rst_n = 1'b1;

        do_req(1'b1, 3'b010, 32'h04, 32'hAABBCCDD, got);
        do_req(1'b1, 3'b010, 32'h08, 32'hCAFEBABE, got);
        do_req(1'b0, 3'b010, 32'h04, 32'h0, got);
        chk("lw_04_lit", got, 32'hAABBCCDD);
        do_req(1'b0, 3'b010, 32'h06, 32'h0, got);
        chk("lw_06_split_lit", got, 32'hBABEAABB);
        do_req(1'b0, 3'b000, 32'h0A, 32'h0, got);
        chk("lb_0a_lit", got, 32'hFFFFFFFE);
        do_req(1'b0, 3'b100, 32'h0A, 32'h0, got);
        chk("lbu_0a_lit", got, 32'h000000FE);
        do_req(1'b1, 3'b001, 32'h07, 32'h0000F00D, got);
        do_req(1'b0, 3'b101, 32'h07, 32'h0, got);
        chk("lhu_07_lit", got, 32'h0000F00D);
        do_req(1'b0, 3'b001, 32'h07, 32'h0, got);
        chk("lh_07_lit", got, 32'hFFFFF00D);
        do_req(1'b0, 3'b001, 32'h05, 32'h0, got);
        do_req(1'b1, 3'b000, 32'h0D, 32'h0000005A, got);
        do_req(1'b0, 3'b100, 32'h0D, 32'h0, got);
        chk("lbu_0d_lit", got, 32'h0000005A);
        do_req(1'b1, 3'b001, 32'h12, 32'h00008001, got);
        do_req(1'b0, 3'b001, 32'h12, 32'h0, got);
        chk("lh_12_lit", got, 32'hFFFF8001);

        do_req(1'b1, 3'b011, 32'h04, 32'h12345678, got);
        chk("st_op011_data", got, 32'h0);
        do_req(1'b0, 3'b110, 32'h04, 32'h0, got);
        chk("ld_op110_data", got, 32'h0);

        // Reset during the HI cycle of a split SW 0x06: only the low word commits.
        w0 = 32'h04;
        push_acc(1'b1, w0, 32'h06, 4, 32'h11223344);
        ref_mem[6] = 8'h44;
        ref_mem[7] = 8'h33;
        @(posedge clk); #1;
        mem_addr = 32'h06; op = 3'b010; st = 1'b1; wdata_in = 32'h11223344; mem_req = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        chk("rst_mid_state", 32'(st_dbg), 32'(ST_HI));
        rst_n = 1'b0; mem_req = 1'b0;
        #1 chk("rst_mid_we", {28'b0, wctrl}, 32'd0);
        @(posedge clk); #1;
        chk("rst_mid_idle", 32'(st_dbg), 32'(ST_IDLE));
        chk("rst_mid_outs", {27'b0, rd_ctrl, wctrl}, 32'd0);
        chk("rst_mid_addr", maddr, 32'd0);
        chk("rst_mid_flags", {29'b0, stall, done, err}, 32'd0);
        rst_n = 1'b1;
        do_req(1'b0, 3'b010, 32'h08, 32'h0, got);
        chk("lw_08_after_rst_lit", got, 32'hCAFEBAF0);
        do_req(1'b0, 3'b010, 32'h04, 32'h0, got);
        chk("lw_04_after_rst_lit", got, 32'h3344CCDD);
        do_req(1'b1, 3'b010, 32'h0B, 32'h01020304, got);
        do_req(1'b0, 3'b010, 32'h0B, 32'h0, got);
        chk("lw_0b_split_lit", got, 32'h01020304);

        // SPLIT_EN=0 instance: word-crossing load is rejected in one cycle.
        @(posedge clk); #1;
        mem_addr = 32'h06; op = 3'b010; st = 1'b0; req2 = 1'b1;
        #1 chk("ns_stall", {31'b0, n2_stall}, 32'd1);
        @(posedge clk); #1;
        chk("ns_done", {31'b0, n2_done}, 32'd1);
        chk("ns_err", {31'b0, n2_err}, 32'd1);
        chk("ns_load", n2_load, 32'd0);
        chk("ns_stall_done", {31'b0, n2_stall}, 32'd0);
        req2 = 1'b0;
        @(posedge clk); #1;
        chk("ns_pulse", {31'b0, n2_done}, 32'd0);
        chk("ns_idle", 32'(n2_state), 32'(ST_IDLE));

        repeat (3) @(posedge clk);
        #1;
        chk("ns_no_access", {31'b0, n2_touched}, 32'd0);
        chk("acc_q_empty", exp_q.size(), 32'd0);
        chk("res_q_empty", res_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
